lcd_write_cmd_data: RTL and testbench

LCD_WRITE_CMD_DATA -- requirements
Module: lcd_write_cmd_data

---
 rtl/lcd_i2c_pkg.sv | 51 +++++
 rtl/i2c_byte_tx.sv | 132 +++++++++++++
 rtl/lcd_write_cmd_data.sv | 96 +++++++++
 tb/tb_lcd_write_cmd_data.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_i2c_pkg.sv
// +----------------------------------------------------------------------+
// | lcd_i2c_pkg : shared timing, PCF8574 bit map and FSM encoding         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package lcd_i2c_pkg;

  localparam int         BIT_PERIOD  = 10;
  localparam logic [3:0] PH_LAST     = 4'(BIT_PERIOD - 1);
  localparam logic [3:0] PH_SDA_SET  = 4'd2;
  localparam logic [3:0] PH_SCL_HIGH = 4'd5;
  localparam logic [3:0] PH_ACK      = 4'd7;
  localparam logic [3:0] IDLE_HOLD   = 4'd10;
  localparam int         NUM_BYTES   = 5;

  localparam int BL_BIT = 3;
  localparam int EN_BIT = 2;
  localparam int RW_BIT = 1;
  localparam int RS_BIT = 0;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_START = 3'd1;
  localparam state_t ST_SEND  = 3'd2;
  localparam state_t ST_ACK   = 3'd3;
  localparam state_t ST_STOP  = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  typedef struct packed {
    logic [7:0] data;
    logic       rs;
    logic [6:0] addr;
  } xfer_req_t;

  function automatic logic [7:0] lcd_byte(input logic [3:0] nib, input logic en,
                                          input logic rs);
    logic [7:0] b;
    b         = '0;
    b[7:4]    = nib;
    b[BL_BIT] = 1'b1;
    b[EN_BIT] = en;
    b[RW_BIT] = 1'b0;
    b[RS_BIT] = rs;
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_byte_tx.sv
// +----------------------------------------------------------------------+
// | i2c_byte_tx : START / byte / ACK / STOP engine, 10-clock bit period   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module i2c_byte_tx
  import lcd_i2c_pkg::*;
(
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic       go_i,
  input  logic [7:0] byte_i,
  input  logic       more_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o,
  output logic       sda_en_o,
  output logic       load_o,
  output logic       idle_o,
  output logic       done_o
);

  state_t     state_q, state_d;
  logic [3:0] phase_q, phase_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic       sda_q, sda_d;
  logic       nack_q, nack_d;
  logic       wrap;

  assign wrap = (phase_q == PH_LAST);

  always_comb begin
    state_d = state_q;
    phase_d = wrap ? 4'd0 : phase_q + 4'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    sda_d   = sda_q;
    nack_d  = nack_q;
    load_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = 4'd0;
        sda_d   = 1'b1;
        if (go_i) state_d = ST_START;
      end
      ST_START: begin
        // SDA falls as SCL enters its high half, giving 5 clocks of hold
        if (phase_q == PH_SCL_HIGH - 4'd1) sda_d = 1'b0;
        if (wrap) begin
          state_d = ST_SEND;
          shift_d = byte_i;
          bit_d   = 3'd0;
          load_o  = 1'b1;
        end
      end
      ST_SEND: begin
        if (phase_q == PH_SDA_SET - 4'd1) sda_d = shift_q[7];
        if (wrap) begin
          shift_d = {shift_q[6:0], 1'b0};
          if (bit_q == 3'd7) state_d = ST_ACK;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      ST_ACK: begin
        if (phase_q == PH_ACK) nack_d = sda_i;
        if (wrap) begin
          if (!nack_q && more_i) begin
            state_d = ST_SEND;
            shift_d = byte_i;
            bit_d   = 3'd0;
            load_o  = 1'b1;
          end else begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (phase_q == PH_SDA_SET - 4'd1) sda_d = 1'b0;
        if (wrap) begin
          state_d = ST_DONE;
          sda_d   = 1'b1;
        end
      end
      ST_DONE: begin
        phase_d = 4'd0;
        state_d = ST_IDLE;
      end
      default: begin
        phase_d = 4'd0;
        sda_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= 4'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
      sda_q   <= 1'b1;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sda_q   <= sda_d;
      nack_q  <= nack_d;
    end
  end

  always_comb begin
    scl_o = 1'b1;
    case (state_q)
      ST_SEND, ST_ACK, ST_STOP: scl_o = (phase_q >= PH_SCL_HIGH);
      default:                  scl_o = 1'b1;
    endcase
  end

  assign sda_o    = sda_q;
  assign sda_en_o = (state_q != ST_ACK);
  assign idle_o   = (state_q == ST_IDLE);
  assign done_o   = (state_q == ST_DONE);

endmodule

`default_nettype wire

// File: rtl/lcd_write_cmd_data.sv
// +----------------------------------------------------------------------+
// | lcd_write_cmd_data : HD44780 write via PCF8574 I2C expander           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module lcd_write_cmd_data
  import lcd_i2c_pkg::*;
(
  input  logic       clk_1MHz,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       cmd_data,
  input  logic       ena,
  input  logic [6:0] i2c_addr,
  inout  wire        sda,
  output logic       scl,
  output logic       done,
  output logic       sda_en
);

  xfer_req_t  req_q, req_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] hold_q, hold_d;
  logic       go;
  logic       eng_idle;
  logic       eng_load;
  logic       eng_done;
  logic       sda_drv;
  logic       more;
  logic [7:0] cur_byte;

  // a new request is honoured only after the post-DONE idle hold expires
  assign go   = ena && eng_idle && (hold_q == 4'd0);
  assign more = (idx_q < 3'(NUM_BYTES));

  always_comb begin
    req_d  = req_q;
    idx_d  = idx_q;
    hold_d = hold_q;
    if (go) begin
      req_d = '{data: data, rs: cmd_data, addr: i2c_addr};
      idx_d = 3'd0;
    end else if (eng_load) begin
      idx_d = idx_q + 3'd1;
    end
    if (eng_done)            hold_d = IDLE_HOLD;
    else if (hold_q != 4'd0) hold_d = hold_q - 4'd1;
  end

  always_comb begin
    cur_byte = 8'hFF;
    case (idx_q)
      3'd0:    cur_byte = {req_q.addr, 1'b0};
      3'd1:    cur_byte = lcd_byte(req_q.data[7:4], 1'b1, req_q.rs);
      3'd2:    cur_byte = lcd_byte(req_q.data[7:4], 1'b0, req_q.rs);
      3'd3:    cur_byte = lcd_byte(req_q.data[3:0], 1'b1, req_q.rs);
      3'd4:    cur_byte = lcd_byte(req_q.data[3:0], 1'b0, req_q.rs);
      default: cur_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      req_q  <= '0;
      idx_q  <= 3'd0;
      hold_q <= 4'd0;
    end else begin
      req_q  <= req_d;
      idx_q  <= idx_d;
      hold_q <= hold_d;
    end
  end

  i2c_byte_tx u_tx (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .go_i     (go),
    .byte_i   (cur_byte),
    .more_i   (more),
    .sda_i    (sda),
    .scl_o    (scl),
    .sda_o    (sda_drv),
    .sda_en_o (sda_en),
    .load_o   (eng_load),
    .idle_o   (eng_idle),
    .done_o   (eng_done)
  );

  assign done = eng_done;
  assign sda  = sda_en ? sda_drv : 1'bz;

endmodule

`default_nettype wire

// File: tb/tb_lcd_write_cmd_data.sv
// Self-checking bench: I2C bus decoder, ACK/NACK slave and byte-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_lcd_write_cmd_data;

  logic       clk_1MHz = 1'b0;
  logic       rst_n    = 1'b1;
  logic [7:0] data     = 8'd0;
  logic       cmd_data = 1'b0;
  logic       ena      = 1'b0;
  logic [6:0] i2c_addr = 7'd0;
  wire        sda;
  logic       scl;
  logic       done;
  logic       sda_en;

  int   nack_at = 0;
  int   n_bytes = 0;
  logic slave_bit;

  assign slave_bit = (nack_at != 0) && (n_bytes == nack_at);
  assign sda       = sda_en ? 1'bz : slave_bit;

  always #500 clk_1MHz = ~clk_1MHz;

  lcd_write_cmd_data dut (
    .clk_1MHz (clk_1MHz),
    .rst_n    (rst_n),
    .data     (data),
    .cmd_data (cmd_data),
    .ena      (ena),
    .i2c_addr (i2c_addr),
    .sda      (sda),
    .scl      (scl),
    .done     (done),
    .sda_en   (sda_en)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int done_cnt = 0;
  int mon_q[$];
  int exp_q[$];
  int start_cycs[$];
  int stop_cycs[$];

  // Bus decoder: -1 = START, -2 = STOP, 0..255 = byte (ACK bit skipped)
  initial begin
    logic       p_scl;
    logic       p_sda;
    int         bitcnt;
    logic [7:0] shreg;
    p_scl = 1'b1; p_sda = 1'b1; bitcnt = 0; shreg = 8'd0;
    forever begin
      @(negedge clk_1MHz);
      cyc++;
      if (done === 1'b1) done_cnt++;
      if (p_scl && scl && p_sda && !sda) begin
        mon_q.push_back(-1); start_cycs.push_back(cyc);
        bitcnt = 0; n_bytes = 0;
      end else if (p_scl && scl && !p_sda && sda) begin
        mon_q.push_back(-2); stop_cycs.push_back(cyc);
      end else if (!p_scl && scl) begin
        if (bitcnt < 8) begin
          shreg = {shreg[6:0], sda};
          bitcnt++;
          if (bitcnt == 8) begin
            mon_q.push_back(int'(shreg));
            n_bytes++;
          end
        end else begin
          bitcnt = 0;
        end
      end
      p_scl = scl; p_sda = sda;
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic chk_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic chk_seq(input string name);
    int bad;
    bad = -1;
    for (int i = 0; i < exp_q.size() && bad < 0; i++)
      if (i >= mon_q.size() || mon_q[i] != exp_q[i]) bad = i;
    if (bad < 0 && mon_q.size() != exp_q.size()) bad = exp_q.size();
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: bus event %0d got %0d, expected %0d (len got %0d expected %0d)",
               name, bad, (bad < mon_q.size()) ? mon_q[bad] : -99,
               (bad < exp_q.size()) ? exp_q[bad] : -99, mon_q.size(), exp_q.size());
    end
  endtask

  // Reference: one START, address then four nibble strobes, truncated at a NACK, one STOP
  task automatic model(input int addr, input int d, input int rs, input int nk);
    int b[5];
    int hi, lo, n;
    hi = d / 16; lo = d % 16;
    b[0] = addr * 2;
    b[1] = hi * 16 + 12 + rs;
    b[2] = hi * 16 + 8 + rs;
    b[3] = lo * 16 + 12 + rs;
    b[4] = lo * 16 + 8 + rs;
    n = (nk == 0) ? 5 : nk;
    exp_q.delete();
    exp_q.push_back(-1);
    for (int i = 0; i < n; i++) exp_q.push_back(b[i]);
    exp_q.push_back(-2);
  endtask

  task automatic clear_mon();
    mon_q.delete(); start_cycs.delete(); stop_cycs.delete();
  endtask

  task automatic run_xfer(input int addr, input int d, input int rs, input int nk,
                          input string name);
    int base, lat;
    bit got;
    repeat (15) @(negedge clk_1MHz);
    base = done_cnt; clear_mon(); nack_at = nk;
    i2c_addr = addr[6:0]; data = d[7:0]; cmd_data = rs[0]; ena = 1'b1;
    lat = 0; got = 0;
    for (int c = 0; c < 700 && !got; c++) begin
      @(negedge clk_1MHz);
      lat++;
      if (c == 3) begin
        ena = 1'b0;
        i2c_addr = 7'($urandom); data = 8'($urandom); cmd_data = 1'($urandom);
      end
      if (done === 1'b1) got = 1;
    end
    chk({name, " done_seen"}, int'(got), 1);
    if (nk == 0) chk_range({name, " latency"}, lat, 460, 480);
    repeat (30) @(negedge clk_1MHz);
    chk({name, " done_pulses"}, done_cnt - base, 1);
    chk_seq({name, " bytes"});
  endtask

  typedef struct {
    int addr;
    int data;
    int rs;
    int nack_at;
    int n;
    int b[5];
  } vec_t;

  vec_t tbl[5];

  initial begin
    int base, gap, a, d, r, nk;
    bit hit;

    tbl[0] = '{'h27, 'hD4, 0, 0, 5, '{'h4E, 'hDC, 'hD8, 'h4C, 'h48}};
    tbl[1] = '{'h27, 'h41, 1, 0, 5, '{'h4E, 'h4D, 'h49, 'h1D, 'h19}};
    tbl[2] = '{'h27, 'hD4, 0, 1, 1, '{'h4E, 0, 0, 0, 0}};
    tbl[3] = '{'h3F, 'h00, 1, 0, 5, '{'h7E, 'h0D, 'h09, 'h0D, 'h09}};
    tbl[4] = '{'h20, 'hFF, 0, 3, 3, '{'h40, 'hFC, 'hF8, 0, 0}};

    #5 rst_n = 1'b0;
    #20;
    chk("reset scl", int'(scl), 1);
    chk("reset sda_en", int'(sda_en), 1);
    chk("reset sda", int'(sda), 1);
    chk("reset done", int'(done), 0);
    repeat (3) @(negedge clk_1MHz);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      exp_q.delete();
      exp_q.push_back(-1);
      for (int k = 0; k < tbl[i].n; k++) exp_q.push_back(tbl[i].b[k]);
      exp_q.push_back(-2);
      run_xfer(tbl[i].addr, tbl[i].data, tbl[i].rs, tbl[i].nack_at, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 6; i++) begin
      a = int'($urandom_range(0, 127)); d = int'($urandom_range(0, 255));
      r = int'($urandom_range(0, 1));   nk = int'($urandom_range(0, 7));
      if (nk > 5) nk = 0;
      model(a, d, r, nk);
      run_xfer(a, d, r, nk, $sformatf("rand%0d", i));
    end

    // ena held high: two identical transfers with an idle gap between them
    repeat (15) @(negedge clk_1MHz);
    base = done_cnt; clear_mon(); nack_at = 0;
    i2c_addr = 7'h27; data = 8'h5A; cmd_data = 1'b1; ena = 1'b1;
    hit = 0;
    for (int c = 0; c < 1200 && !hit; c++) begin
      @(negedge clk_1MHz);
      if (done_cnt - base >= 2) hit = 1;
    end
    ena = 1'b0;
    chk("b2b two_done_in_budget", int'(hit), 1);
    repeat (30) @(negedge clk_1MHz);
    chk("b2b done_pulses", done_cnt - base, 2);
    model('h27, 'h5A, 1, 0);
    for (int i = 0; i < 7; i++) exp_q.push_back(exp_q[i]);
    chk_seq("b2b bytes");
    gap = (start_cycs.size() > 1 && stop_cycs.size() > 0) ? start_cycs[1] - stop_cycs[0] : -1;
    chk_range("b2b idle_gap", gap, 10, 1000);

    // reset during the third payload byte
    repeat (15) @(negedge clk_1MHz);
    base = done_cnt; clear_mon(); nack_at = 0;
    i2c_addr = 7'h27; data = 8'hD4; cmd_data = 1'b0; ena = 1'b1;
    hit = 0;
    for (int c = 0; c < 400 && !hit; c++) begin
      @(negedge clk_1MHz);
      if (n_bytes >= 3) hit = 1;
    end
    chk("rst_mid reached_byte3", int'(hit), 1);
    repeat (40) @(negedge clk_1MHz);
    #100 rst_n = 1'b0;
    #1;
    chk("rst_mid scl", int'(scl), 1);
    chk("rst_mid sda_en", int'(sda_en), 1);
    chk("rst_mid sda", int'(sda), 1);
    chk("rst_mid done", int'(done), 0);
    ena = 1'b0;
    repeat (5) @(negedge clk_1MHz);
    rst_n = 1'b1;
    repeat (600) @(negedge clk_1MHz);
    chk("rst_mid no_done", done_cnt - base, 0);
    model('h27, 'hD4, 0, 0);
    run_xfer('h27, 'hD4, 0, 0, "after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
